brownout_dig_mc: RTL and testbench
==================================

# brownout_dig_mc

Multi-channel, parametrised successor to the single-channel brownout digital controller. It serves NCH analog brownout comparators with:
- per-channel trip-select decoders;
- per-channel synchronisers and restartable power-good one-shots;
- a shared RC-oscillator enable;
- sticky brownout-event flags.

It sits between the analog comparator/reference array and the system reset/interrupt logic, clocked from the local RC oscillator.

## Interface
Parameters:
- NCH, 2: number of monitored channels (1–8).
- SEL_W, 3: trip-select width per channel; decoded to 2^SEL_W one-hot.
- CNT_W, 12: one-shot counter width (4–16).
- SHORT_W, 9: short-mode one-shot length exponent (2 ≤ SHORT_W < CNT_W).

Ports:
- osc_ck  in  1  RC-oscillator clock, sole clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low forces all channels idle/timed-out.
- ch_mask  in  NCH  per-channel enable; 0 treats channel as disabled.
- dcomp  in  NCH  asynchronous comparator outputs; 1 = supply below trip.
- vtrip  in  NCH*SEL_W  per-channel trip select, channel i at [i*SEL_W +: SEL_W].
- force_ena_rc_osc  in  1  forces osc_ena high.
- force_dis_rc_osc  in  1  forces osc_ena low unless force_ena_rc_osc.
- force_short_oneshot  in  1  selects short one-shot length.
- evt_clr  in  1  clears sticky flags (and event counters).
- vtrip_decoded  out  NCH*2^SEL_W  combinational one-hot decode per channel.
- osc_ena  out  1  combinational oscillator request.
- out_unbuf  out  NCH  per-channel power-good, 1 = good.
- brout_any  out  1  OR of ~out_unbuf over enabled channels.
- timed_out  out  NCH  debug: counter at all-ones.
- evt_sticky  out  NCH  latched brownout-event flags.
- evt_cnt  out  NCH*8  per-channel event counters; present only with BROWNOUT_EVT_CNT_EN.

## Operation
- **Decoder:** vtrip_decoded[i] bit k is 1 iff vtrip field i == k. Purely combinational and independent of rst/ena.
- **Synchroniser:** dcomp[i] passes through 2 flops to give dcomp_s[i]. Synchroniser flops reset to 0 on rst. They also hold 0 while ena=0 or ch_mask[i]=0.
- **Channel active:** act[i] = ena & ch_mask[i] & !rst.
- **Counter cnt[i]**, priority order per edge:
  1. rst or !act[i] → all-ones.
  2. dcomp_s[i] → 0.
  3. timed_out[i] → hold.
  4. force_short_oneshot & (cnt < 2^CNT_W − 2^SHORT_W) → load 2^CNT_W − 2^SHORT_W.
  5. Otherwise → cnt+1.
- Incrementing never wraps past all-ones; step 3 prevents it.
- timed_out[i] = (cnt[i] == all-ones).
- out_unbuf[i] = !dcomp_s[i] & timed_out[i].
- brout_any = |(~out_unbuf & ch_mask) & ena.
- osc_ena = force_ena_rc_osc | (!force_dis_rc_osc & ena & (|(dcomp & ch_mask) | |(~out_unbuf & ch_mask))).
  - The raw dcomp term is deliberate: the oscillator must start before any synchronised state exists.
- **Event detect:** evt_rise[i] = dcomp_s[i] & !dcomp_s_d[i], where dcomp_s_d is a third flop. evt_rise counts only while act[i].
- **evt_sticky[i]:**
  - set on evt_rise[i];
  - cleared on evt_clr;
  - set wins over a simultaneous clear;
  - rst → 0.
  - Sticky flags survive ena/ch_mask deassertion.

## Timing
Reset values after rst:
- cnt = all-ones, so out_unbuf = all 1 and timed_out = all 1.
- brout_any = 0, evt_sticky = 0, evt_cnt = 0.
- osc_ena is 0, provided no force input is high and dcomp is low.

Latencies and boundary behaviour:
- **dcomp rise → out_unbuf fall:** 2 osc_ck edges (synchroniser). evt_sticky sets 1 edge later.
- **dcomp fall → out_unbuf rise:**
  - 2 edges (synchroniser), then 2^CNT_W−1 further edges in normal mode (4095 at default);
  - 2^SHORT_W edges in short mode (512 at default).
- **Glitch during count:** dcomp_s reasserting at any count restarts from 0. No partial credit.
- **force_short_oneshot mid-count:**
  - At a count below the short base, it jumps to the base on the next edge.
  - At or above the base, counting continues unchanged.
- **ena or ch_mask dropped mid-count:** cnt goes to all-ones on the next edge, making the channel good immediately once idle.
- **rst mid-count:** same as above. Sticky flags and counters also clear.

## Configuration
- Macro: BROWNOUT_EVT_CNT_EN.
- Defined:
  - evt_cnt is present: an 8-bit per-channel counter.
  - Increments on evt_rise[i] and saturates at 255.
  - evt_clr clears it to 0; evt_clr together with evt_rise loads 1.
  - rst → 0.
- Undefined:
  - the evt_cnt port and its logic are absent;
  - all other behaviour is identical.

## Test plan
Defaults: NCH=2, SEL_W=3, CNT_W=12, SHORT_W=9, ena=1, ch_mask=2'b11.
- **Reset/decoder:** rst pulse, vtrip={3'd5,3'd0} → out_unbuf=2'b11, brout_any=0, vtrip_decoded={8'h20,8'h01}.
- **Normal one-shot:** dcomp[0] high 10 cycles then low →
  - out_unbuf[0] low 2 edges after rise; evt_sticky[0]=1;
  - out_unbuf[0] high exactly 2+4095 edges after fall;
  - channel 1 unaffected.
- **Short mode:** force_short_oneshot=1, same pulse on dcomp[1] → out_unbuf[1] high 2+512 edges after fall.
- **Restart/mask:**
  - dcomp[0] re-pulses at count 1000 → full 4095 recount.
  - ch_mask[0]=0 mid-count → out_unbuf[0]=1 next edge; brout_any=0.
- **Oscillator forcing:**
  - force_dis=1 with dcomp=2'b01 → osc_ena=0.
  - Add force_ena=1 → osc_ena=1.
  - ena=0, no forces → osc_ena=0.
- **Events (macro on):**
  - 300 dcomp[0] pulses → evt_cnt[0]=255.
  - evt_clr coincident with a rising event → evt_cnt[0]=1 and evt_sticky[0]=1.

Source files
------------

// File: rtl/brownout_dig_mc.sv
// Multi-channel brownout digital controller.
// Per channel: trip-select decoder, 2-flop comparator synchroniser, restartable
// power-good one-shot and a sticky brownout-event flag. All channels share the
// RC-oscillator request.
// Optional feature macro: BROWNOUT_EVT_CNT_EN adds 8-bit saturating per-channel
// event counters on the evt_cnt port.
module brownout_dig_mc #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned SHORT_W = 9
) (
  input  logic                          osc_ck,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [NCH-1:0]                ch_mask,
  input  logic [NCH-1:0]                dcomp,
  input  logic [NCH*SEL_W-1:0]          vtrip,
  input  logic                          force_ena_rc_osc,
  input  logic                          force_dis_rc_osc,
  input  logic                          force_short_oneshot,
  input  logic                          evt_clr,
  output logic [NCH*(1<<SEL_W)-1:0]     vtrip_decoded,
  output logic                          osc_ena,
  output logic [NCH-1:0]                out_unbuf,
  output logic                          brout_any,
  output logic [NCH-1:0]                timed_out,
  output logic [NCH-1:0]                evt_sticky
`ifdef BROWNOUT_EVT_CNT_EN
  ,
  output logic [NCH*8-1:0]              evt_cnt
`endif
);

  localparam int unsigned      DEC_W      = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  // Short mode starts counting here so that 2^SHORT_W steps remain to all-ones.
  localparam logic [CNT_W-1:0] SHORT_BASE = ~CNT_W'((32'd1 << SHORT_W) - 32'd1);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic             gate;
    logic             act;
    logic             evt_rise;
    logic             tmo;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [SEL_W-1:0] sel;
    logic [DEC_W-1:0] dec;

    assign gate     = ena & ch_mask[g];
    assign act      = gate & ~rst;
    assign sel      = vtrip[g*SEL_W +: SEL_W];
    assign tmo      = (cnt_q == CNT_MAX);
    assign evt_rise = s2_q & ~s3_q & act;

    // One-hot trip-select decode, independent of reset and enable.
    always_comb begin
      dec      = '0;
      dec[sel] = 1'b1;
    end

    // Synchroniser next state; flops are held clear while the channel is off.
    always_comb begin
      s1_d = dcomp[g] & gate;
      s2_d = s1_q & gate;
      s3_d = s2_q & gate;
    end

    // Synchroniser and edge-detect delay flops.
    always_ff @(posedge osc_ck) begin
      if (rst) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
        s3_q <= 1'b0;
      end else begin
        s1_q <= s1_d;
        s2_q <= s2_d;
        s3_q <= s3_d;
      end
    end

    // One-shot counter: idle parks at all-ones, brownout restarts from zero.
    always_comb begin
      cnt_d = cnt_q;
      if (!act) begin
        cnt_d = CNT_MAX;
      end else if (s2_q) begin
        cnt_d = '0;
      end else if (tmo) begin
        cnt_d = cnt_q;
      end else if (force_short_oneshot && (cnt_q < SHORT_BASE)) begin
        cnt_d = SHORT_BASE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // One-shot counter register.
    always_ff @(posedge osc_ck) begin
      if (rst) begin
        cnt_q <= CNT_MAX;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Sticky event flag: a new event wins over a simultaneous clear.
    always_comb begin
      sticky_d = (evt_clr ? 1'b0 : sticky_q) | evt_rise;
    end

    // Sticky flag register; survives enable/mask deassertion.
    always_ff @(posedge osc_ck) begin
      if (rst) begin
        sticky_q <= 1'b0;
      end else begin
        sticky_q <= sticky_d;
      end
    end

`ifdef BROWNOUT_EVT_CNT_EN
    logic [7:0] ecnt_q, ecnt_d;

    // Saturating event counter; clear with a coincident event loads one.
    always_comb begin
      ecnt_d = ecnt_q;
      if (evt_clr) begin
        ecnt_d = evt_rise ? 8'd1 : 8'd0;
      end else if (evt_rise && (ecnt_q != 8'hFF)) begin
        ecnt_d = ecnt_q + 8'd1;
      end
    end

    // Event counter register.
    always_ff @(posedge osc_ck) begin
      if (rst) begin
        ecnt_q <= 8'd0;
      end else begin
        ecnt_q <= ecnt_d;
      end
    end

    assign evt_cnt[g*8 +: 8] = ecnt_q;
`endif

    assign vtrip_decoded[g*DEC_W +: DEC_W] = dec;
    assign timed_out[g]  = tmo;
    assign out_unbuf[g]  = ~s2_q & tmo;
    assign evt_sticky[g] = sticky_q;
  end : g_ch

  // Any enabled channel currently not power-good.
  assign brout_any = ena & (|(~out_unbuf & ch_mask));

  // Raw dcomp term lets the oscillator start before the synchronisers can run.
  assign osc_ena = force_ena_rc_osc |
                   (~force_dis_rc_osc & ena &
                    ((|(dcomp & ch_mask)) | (|(~out_unbuf & ch_mask))));

endmodule

// File: tb/tb_brownout_dig_mc.sv
// Self-checking bench for brownout_dig_mc at default parameters.
module tb_brownout_dig_mc;

  localparam int unsigned NCH     = 2;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CNT_W   = 12;
  localparam int unsigned SHORT_W = 9;

  logic                  osc_ck = 1'b0;
  logic                  rst = 1'b1;
  logic                  ena = 1'b1;
  logic [NCH-1:0]        ch_mask = 2'b11;
  logic [NCH-1:0]        dcomp = 2'b00;
  logic [NCH*SEL_W-1:0]  vtrip = {3'd5, 3'd0};
  logic                  force_ena_rc_osc = 1'b0;
  logic                  force_dis_rc_osc = 1'b0;
  logic                  force_short_oneshot = 1'b0;
  logic                  evt_clr = 1'b0;
  logic [NCH*8-1:0]      vtrip_decoded;
  logic                  osc_ena;
  logic [NCH-1:0]        out_unbuf;
  logic                  brout_any;
  logic [NCH-1:0]        timed_out;
  logic [NCH-1:0]        evt_sticky;
`ifdef BROWNOUT_EVT_CNT_EN
  logic [NCH*8-1:0]      evt_cnt;
`endif

  brownout_dig_mc #(
    .NCH(NCH), .SEL_W(SEL_W), .CNT_W(CNT_W), .SHORT_W(SHORT_W)
  ) dut (
    .osc_ck(osc_ck),
    .rst(rst),
    .ena(ena),
    .ch_mask(ch_mask),
    .dcomp(dcomp),
    .vtrip(vtrip),
    .force_ena_rc_osc(force_ena_rc_osc),
    .force_dis_rc_osc(force_dis_rc_osc),
    .force_short_oneshot(force_short_oneshot),
    .evt_clr(evt_clr),
    .vtrip_decoded(vtrip_decoded),
    .osc_ena(osc_ena),
    .out_unbuf(out_unbuf),
    .brout_any(brout_any),
    .timed_out(timed_out),
    .evt_sticky(evt_sticky)
`ifdef BROWNOUT_EVT_CNT_EN
    ,
    .evt_cnt(evt_cnt)
`endif
  );

  always #5 osc_ck = ~osc_ck;

  typedef struct {
    logic        ena;
    logic [1:0]  mask;
    logic [1:0]  dcomp;
    logic        fe;
    logic        fd;
    logic [5:0]  vtrip;
    logic        exp_osc;
    logic [15:0] exp_dec;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   lat_q[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge osc_ck);
      #1;
    end
  endtask

  // Edges until out_unbuf[ch] reaches val; -1 if the budget runs out.
  task automatic measure(input int ch, input logic val, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      step(1);
      if (out_unbuf[ch] === val) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    vec_t e;

    vecs[0] = '{1'b1, 2'b11, 2'b00, 1'b0, 1'b0, {3'd5, 3'd0}, 1'b0, 16'h2001};
    vecs[1] = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b1, {3'd7, 3'd3}, 1'b0, 16'h8008};
    vecs[2] = '{1'b1, 2'b11, 2'b01, 1'b1, 1'b1, {3'd1, 3'd2}, 1'b1, 16'h0204};
    vecs[3] = '{1'b0, 2'b11, 2'b01, 1'b0, 1'b0, {3'd6, 3'd4}, 1'b0, 16'h4010};
    vecs[4] = '{1'b1, 2'b11, 2'b01, 1'b0, 1'b0, {3'd2, 3'd7}, 1'b1, 16'h0480};
    vecs[5] = '{1'b1, 2'b10, 2'b01, 1'b0, 1'b0, {3'd3, 3'd1}, 1'b0, 16'h0802};
    vecs[6] = '{1'b1, 2'b10, 2'b10, 1'b0, 1'b0, {3'd4, 3'd6}, 1'b1, 16'h1040};
    vecs[7] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, {3'd0, 3'd5}, 1'b1, 16'h0120};

    // Reset state and decoder
    step(3);
    rst = 1'b0;
    check("rst_out_unbuf", 32'(out_unbuf), 32'h3);
    check("rst_timed_out", 32'(timed_out), 32'h3);
    check("rst_brout_any", 32'(brout_any), 32'h0);
    check("rst_sticky", 32'(evt_sticky), 32'h0);
    check("rst_osc_ena", 32'(osc_ena), 32'h0);
    check("rst_decode", 32'(vtrip_decoded), 32'h2001);
`ifdef BROWNOUT_EVT_CNT_EN
    check("rst_evt_cnt", 32'(evt_cnt), 32'h0);
`endif
    step(1);

    // Combinational vectors, applied and withdrawn between clock edges
    for (int v = 0; v < 8; v++) begin
      ena = vecs[v].ena;
      ch_mask = vecs[v].mask;
      dcomp = vecs[v].dcomp;
      force_ena_rc_osc = vecs[v].fe;
      force_dis_rc_osc = vecs[v].fd;
      vtrip = vecs[v].vtrip;
      sb_q.push_back(vecs[v]);
      #1;
      e = sb_q.pop_front();
      check($sformatf("vec%0d_osc_ena", v), 32'(osc_ena), 32'(e.exp_osc));
      check($sformatf("vec%0d_decode", v), 32'(vtrip_decoded), 32'(e.exp_dec));
      check($sformatf("vec%0d_brout_any", v), 32'(brout_any), 32'h0);
      ena = 1'b1; ch_mask = 2'b11; dcomp = 2'b00;
      force_ena_rc_osc = 1'b0; force_dis_rc_osc = 1'b0;
      step(1);
    end

    // Normal one-shot on channel 0
    dcomp[0] = 1'b1;
    lat_q.push_back(2);
    measure(0, 1'b0, 20, n);
    check("norm_fall_lat", 32'(n), 32'(lat_q.pop_front()));
    check("norm_sticky_early", 32'(evt_sticky), 32'h0);
    check("norm_ch1_good", 32'(out_unbuf), 32'h2);
    step(1);
    check("norm_sticky_set", 32'(evt_sticky), 32'h1);
    step(7);
    check("norm_brout_any", 32'(brout_any), 32'h1);
    check("norm_osc_ena", 32'(osc_ena), 32'h1);
    lat_q.push_back(2 + 4095);
    dcomp[0] = 1'b0;
    measure(0, 1'b1, 5000, n);
    check("norm_rise_lat", 32'(n), 32'(lat_q.pop_front()));
    check("norm_out_unbuf", 32'(out_unbuf), 32'h3);
    check("norm_timed_out", 32'(timed_out), 32'h3);

    // Short one-shot on channel 1
    force_short_oneshot = 1'b1;
    dcomp[1] = 1'b1;
    step(10);
    lat_q.push_back(2 + 512);
    dcomp[1] = 1'b0;
    measure(1, 1'b1, 1000, n);
    check("short_rise_lat", 32'(n), 32'(lat_q.pop_front()));
    force_short_oneshot = 1'b0;

    // Restart at count 1000 gives a full recount
    dcomp[0] = 1'b1;
    step(5);
    dcomp[0] = 1'b0;
    step(2 + 1000);
    check("restart_mid_good", 32'(out_unbuf[0]), 32'h0);
    dcomp[0] = 1'b1;
    step(3);
    lat_q.push_back(2 + 4095);
    dcomp[0] = 1'b0;
    measure(0, 1'b1, 5000, n);
    check("restart_rise_lat", 32'(n), 32'(lat_q.pop_front()));

    // Mask dropped mid-count
    dcomp[0] = 1'b1;
    step(5);
    dcomp[0] = 1'b0;
    step(500);
    check("mask_pre_good", 32'(out_unbuf[0]), 32'h0);
    check("mask_pre_brout", 32'(brout_any), 32'h1);
    ch_mask = 2'b10;
    step(1);
    check("mask_good", 32'(out_unbuf[0]), 32'h1);
    check("mask_brout", 32'(brout_any), 32'h0);
    check("mask_osc_ena", 32'(osc_ena), 32'h0);
    check("mask_sticky_kept", 32'(evt_sticky), 32'h3);
    ch_mask = 2'b11;
    step(2);
    check("mask_restore", 32'(out_unbuf), 32'h3);
    evt_clr = 1'b1;
    step(1);
    evt_clr = 1'b0;
    check("clr_sticky", 32'(evt_sticky), 32'h0);

    // Clear coincident with a new event: set wins
    dcomp[0] = 1'b1;
    step(2);
    evt_clr = 1'b1;
    step(1);
    evt_clr = 1'b0;
    check("clr_rise_sticky", 32'(evt_sticky), 32'h1);
`ifdef BROWNOUT_EVT_CNT_EN
    check("clr_rise_cnt", 32'(evt_cnt[7:0]), 32'h1);
`endif

    // Reset mid-count
    dcomp[0] = 1'b0;
    step(100);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rstmid_out_unbuf", 32'(out_unbuf), 32'h3);
    check("rstmid_timed_out", 32'(timed_out), 32'h3);
    check("rstmid_sticky", 32'(evt_sticky), 32'h0);
    check("rstmid_brout", 32'(brout_any), 32'h0);
`ifdef BROWNOUT_EVT_CNT_EN
    check("rstmid_evt_cnt", 32'(evt_cnt), 32'h0);
`endif

    // Global enable dropped mid-count
    dcomp[1] = 1'b1;
    step(5);
    dcomp[1] = 1'b0;
    step(50);
    check("ena_pre_good", 32'(out_unbuf[1]), 32'h0);
    ena = 1'b0;
    step(1);
    check("ena_good", 32'(out_unbuf), 32'h3);
    check("ena_brout", 32'(brout_any), 32'h0);
    check("ena_osc", 32'(osc_ena), 32'h0);
    ena = 1'b1;
    step(1);
    check("ena_restore", 32'(out_unbuf), 32'h3);
    check("ena_sticky_kept", 32'(evt_sticky), 32'h2);

`ifdef BROWNOUT_EVT_CNT_EN
    // Counter saturation over 300 events
    evt_clr = 1'b1;
    step(1);
    evt_clr = 1'b0;
    check("sat_cleared", 32'(evt_cnt), 32'h0);
    for (int p = 0; p < 300; p++) begin
      dcomp[0] = 1'b1;
      step(3);
      dcomp[0] = 1'b0;
      step(3);
    end
    check("sat_cnt0", 32'(evt_cnt[7:0]), 32'd255);
    check("sat_cnt1", 32'(evt_cnt[15:8]), 32'd0);
    check("sat_sticky", 32'(evt_sticky), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
